om_max_search: RTL and testbench
================================

# om_max_search

Upstream feeder for the 23x23 threshold stage. It scans the 81x81 output map (OM) for the largest classifier response and presents the value and its address as a one-cycle candidate. It waits for the threshold stage's verdict. On an accepted face it zeroes (suppresses) a window of the map at the winning position and rescans. On a rejection it terminates the search and pulses `oFinish`, which also clears the threshold stage.

## Interface
Parameters:
- `MAP_W`, default 81: map width (columns).
- `MAP_H`, default 81: map height (rows); `MAP_W*MAP_H` ≤ 8192.
- `SUP`, default 23: suppression window side, in map cells.
- `MAX_FACES`, default 16: maximum number of accepted faces per frame.

Ports (reset `iReset_n` is synchronous, active-low; clock is `iClk`):
- `iClk` in 1: clock, rising edge.
- `iReset_n` in 1: synchronous active-low reset.
- `iStart` in 1: pulse that begins a frame search; ignored while `oBusy`.
- `iData_from_OM` in 32: OM read data, valid one cycle after `oAddr_OM`.
- `iFace_ready` in 1: threshold stage accepted the current candidate.
- `iEnd` in 1: threshold stage rejected the candidate (max below threshold).
- `oAddr_OM` out 13: OM address, used for reads in SCAN and writes in CLEAR.
- `oOm_sel` out 1: high when this block owns the OM port (SCAN/CLEAR); the top level muxes in the threshold address otherwise.
- `oWr_OM` out 1: OM write enable; write data is always 0.
- `oMax_val` out 32: candidate maximum value.
- `oPosition` out 13: candidate address (the first occurrence of the max).
- `oOutput_ready` out 1: one-cycle candidate strobe.
- `oBusy` out 1: high in any state other than IDLE.
- `oFinish` out 1: one-cycle pulse at the end of the search.
- `oFace_count` out 8: number of faces accepted this frame.

## Operation
- States: IDLE, SCAN, DRAIN, REPORT, WAIT, CLEAR, DONE.
- **IDLE:**
  - On `iStart`: go to SCAN and zero `oFace_count`.
  - Entry into SCAN (from IDLE or CLEAR) resets address, row, col, max and argmax.
- **SCAN:**
  - Issues addresses 0 .. `MAP_SIZE`-1, one per cycle, with `oOm_sel`=1.
  - Tracks a row/col counter pair in step with the address; no divider is used.
  - The compare runs on data returned for the previous cycle's address, using a 1-cycle delayed address/row/col.
  - Compare is unsigned and strict `>`, so on a tie the lowest address wins.
  - The running max initialises to 0 and the argmax to address 0, row 0, col 0.
  - An all-zero map therefore reports value 0 at position 0.
- **DRAIN:** one cycle that compares the last read datum.
- **REPORT:** latch `oMax_val`/`oPosition`, assert `oOutput_ready` for one cycle, then go to WAIT.
- **WAIT:** hold outputs and respond to the threshold stage's verdict.
  - `iEnd`: go to DONE. `iEnd` has priority if it coincides with `iFace_ready`.
  - `iFace_ready`: increment `oFace_count`.
    - If the count reaches `MAX_FACES`, go to DONE.
    - Otherwise go to CLEAR.
- **CLEAR:**
  - Writes 0 (`oWr_OM`=1) to every cell of rows `r0`..min(`r0`+`SUP`-1, `MAP_H`-1) × cols `c0`..min(`c0`+`SUP`-1, `MAP_W`-1), where (`r0`, `c0`) is the stored argmax.
  - Order is row-major, one write per cycle.
  - The address is computed incrementally: +1 per column, and + `MAP_W` − width + 1 on a row step.
  - After the last write, go to SCAN.
- **DONE:** pulse `oFinish` for one cycle, then go to IDLE. `oMax_val`/`oPosition` keep their last values.
- Width rules:
  - The address is 13-bit and never wraps: the scan stops at `MAP_SIZE`-1, and the clipped window never exceeds the map.
  - `oFace_count` saturates by construction at `MAX_FACES`.

## Timing
- Reset (synchronous, takes priority over everything): state=IDLE and every output is 0: `oAddr_OM`, `oOm_sel`, `oWr_OM`, `oMax_val`, `oPosition`, `oOutput_ready`, `oBusy`, `oFinish`, `oFace_count`.
- A reset asserted mid-SCAN or mid-CLEAR stops all writes in the same cycle.
- `oBusy` rises the cycle after `iStart`.
- `oOm_sel` is high exactly during the SCAN and CLEAR cycles.
- Scan latency, from `iStart` sampled to `oOutput_ready` high: `MAP_SIZE` + 3 cycles (6564 at defaults).
- Clear duration: w × h cycles, where w/h are the clipped widths (full window 529 cycles).
- Rescan: a full `MAP_SIZE` + 2 cycles after CLEAR ends.
- `oOutput_ready` is never asserted in two consecutive cycles.
- The candidate outputs stay stable from REPORT until the next REPORT.
- `oFinish` comes 1 cycle after `iEnd` is sampled, or after the `MAX_FACES`-th `iFace_ready`.

## Test plan
- **Single peak:**
  - Stimulus: map all 0x10, cell 1000 = 0x5000000; `iStart`; `iEnd` returned after the second report.
  - Required: first report value 0x5000000 at position 1000, 6564 cycles after start.
  - Required: 529 writes covering rows 12–34, cols 28–50; second report 0x10 at 0; `oFinish` 1 cycle after `iEnd`; `oFace_count`=1.
- **Tie:** cells 200 and 4000 both = 0x7000000 → the first report has position 200.
- **Edge clip:** peak at 6560 (row 80, col 80) → exactly 1 write, to address 6560, then rescan.
- **Face limit:** with `MAX_FACES`=2, always answer `iFace_ready` → two reports, then `oFinish` without a third scan; `oFace_count`=2.
- **Simultaneous verdict:** `iEnd` and `iFace_ready` high in the same cycle → DONE, no CLEAR writes, count unchanged.
- **Reset/start guard:**
  - `iReset_n` low mid-CLEAR → all outputs 0 the next cycle and no further `oWr_OM`.
  - `iStart` pulsed while busy → ignored: no restart, address sequence unchanged.

Source files
------------

// File: rtl/om_max_search.sv
// Output-map maximum search: scans the OM for the largest response, hands it to the
// threshold stage, and on acceptance zeroes a window around the winner and rescans.
module om_max_search #(
  parameter int MAP_W     = 81,
  parameter int MAP_H     = 81,
  parameter int SUP       = 23,
  parameter int MAX_FACES = 16
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iStart,
  input  logic [31:0] iData_from_OM,
  input  logic        iFace_ready,
  input  logic        iEnd,
  output logic [12:0] oAddr_OM,
  output logic        oOm_sel,
  output logic        oWr_OM,
  output logic [31:0] oMax_val,
  output logic [12:0] oPosition,
  output logic        oOutput_ready,
  output logic        oBusy,
  output logic        oFinish,
  output logic [7:0]  oFace_count
);

  localparam int         MAP_SIZE   = MAP_W * MAP_H;
  localparam logic [12:0] LAST_ADDR  = 13'(MAP_SIZE - 1);
  localparam logic [12:0] LAST_COL   = 13'(MAP_W - 1);
  localparam logic [12:0] LAST_ROW   = 13'(MAP_H - 1);
  localparam logic [12:0] ROW_STRIDE = 13'(MAP_W);
  localparam logic [12:0] SUP_M1     = 13'(SUP - 1);
  localparam logic [7:0]  FACE_LIMIT = 8'(MAX_FACES);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, REPORT, WAIT, CLEAR, DONE} state_t;

  state_t      stateReg, stateNext;
  logic [12:0] addrReg, rowReg, colReg;
  logic [12:0] dAddrReg, dRowReg, dColReg;
  logic        cmpValidReg;
  logic [31:0] maxReg;
  logic [12:0] argAddrReg, argRowReg, argColReg;
  logic [12:0] clrRowLastReg, clrColLastReg;
  logic [31:0] maxValReg;
  logic [12:0] positionReg;
  logic        readyReg;
  logic [7:0]  faceCountReg;

  logic        scanLastCol, clearLastCol, clearLastCell, faceLimitHit;
  logic [12:0] rowSum, colSum, winRowEnd, winColEnd;

  assign scanLastCol   = (colReg == LAST_COL);
  assign clearLastCol  = (colReg == clrColLastReg);
  assign clearLastCell = clearLastCol && (rowReg == clrRowLastReg);
  assign faceLimitHit  = ((faceCountReg + 8'd1) == FACE_LIMIT);

  // Suppression window clipped against the bottom/right map edges.
  assign rowSum    = argRowReg + SUP_M1;
  assign colSum    = argColReg + SUP_M1;
  assign winRowEnd = (rowSum > LAST_ROW) ? LAST_ROW : rowSum;
  assign winColEnd = (colSum > LAST_COL) ? LAST_COL : colSum;

  always_ff @(posedge iClk) begin
    if (!iReset_n) stateReg <= IDLE;
    else           stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    oOm_sel   = 1'b0;
    oWr_OM    = 1'b0;
    oBusy     = 1'b1;
    oFinish   = 1'b0;
    case (stateReg)
      IDLE: begin
        oBusy = 1'b0;
        if (iStart) stateNext = SCAN;
      end
      SCAN: begin
        oOm_sel = 1'b1;
        if (addrReg == LAST_ADDR) stateNext = DRAIN;
      end
      DRAIN:  stateNext = REPORT;
      REPORT: stateNext = WAIT;
      WAIT: begin
        if (iEnd)             stateNext = DONE;
        else if (iFace_ready) stateNext = faceLimitHit ? DONE : CLEAR;
      end
      CLEAR: begin
        oOm_sel = 1'b1;
        // Gated by reset so a reset cuts the write in the very cycle it is asserted.
        oWr_OM  = iReset_n;
        if (clearLastCell) stateNext = SCAN;
      end
      DONE: begin
        oFinish   = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      addrReg       <= '0;
      rowReg        <= '0;
      colReg        <= '0;
      dAddrReg      <= '0;
      dRowReg       <= '0;
      dColReg       <= '0;
      cmpValidReg   <= 1'b0;
      maxReg        <= '0;
      argAddrReg    <= '0;
      argRowReg     <= '0;
      argColReg     <= '0;
      clrRowLastReg <= '0;
      clrColLastReg <= '0;
      maxValReg     <= '0;
      positionReg   <= '0;
      readyReg      <= 1'b0;
      faceCountReg  <= '0;
    end else begin
      readyReg    <= 1'b0;
      cmpValidReg <= (stateReg == SCAN);
      dAddrReg    <= addrReg;
      dRowReg     <= rowReg;
      dColReg     <= colReg;

      if (stateReg == IDLE && iStart) faceCountReg <= '0;

      if (stateReg != SCAN && stateNext == SCAN) begin
        addrReg    <= '0;
        rowReg     <= '0;
        colReg     <= '0;
        maxReg     <= '0;
        argAddrReg <= '0;
        argRowReg  <= '0;
        argColReg  <= '0;
      end

      if (stateReg == SCAN && addrReg != LAST_ADDR) begin
        addrReg <= addrReg + 13'd1;
        if (scanLastCol) begin
          colReg <= '0;
          rowReg <= rowReg + 13'd1;
        end else begin
          colReg <= colReg + 13'd1;
        end
      end

      // Data returned now belongs to last cycle's address; strict > keeps the first max.
      if (cmpValidReg && (iData_from_OM > maxReg)) begin
        maxReg     <= iData_from_OM;
        argAddrReg <= dAddrReg;
        argRowReg  <= dRowReg;
        argColReg  <= dColReg;
      end

      if (stateReg == REPORT) begin
        maxValReg   <= maxReg;
        positionReg <= argAddrReg;
        readyReg    <= 1'b1;
      end

      if (stateReg == WAIT && !iEnd && iFace_ready) faceCountReg <= faceCountReg + 8'd1;

      if (stateReg == WAIT && stateNext == CLEAR) begin
        addrReg       <= argAddrReg;
        rowReg        <= argRowReg;
        colReg        <= argColReg;
        clrRowLastReg <= winRowEnd;
        clrColLastReg <= winColEnd;
      end

      if (stateReg == CLEAR && !clearLastCell) begin
        if (clearLastCol) begin
          rowReg  <= rowReg + 13'd1;
          colReg  <= argColReg;
          addrReg <= addrReg + ROW_STRIDE - (clrColLastReg - argColReg);
        end else begin
          colReg  <= colReg + 13'd1;
          addrReg <= addrReg + 13'd1;
        end
      end
    end
  end

  assign oAddr_OM      = addrReg;
  assign oMax_val      = maxValReg;
  assign oPosition     = positionReg;
  assign oOutput_ready = readyReg;
  assign oFace_count   = faceCountReg;

endmodule

// File: tb/tb_om_max_search.sv
// Bench for om_max_search: directed frames on a full-size map plus randomized frames
// on a small map, both checked against an array model of the search and suppression.
module tb_om_max_search;

  localparam int AW = 81, AH = 81, ASZ = AW * AH, ASUP = 23;
  localparam int BW = 9, BH = 7, BSZ = BW * BH, BSUP = 3, BMAX = 2;

  logic iClk = 1'b0;
  always #5 iClk = ~iClk;

  logic        aRst_n, aStart, aFace, aEnd;
  logic [31:0] aData, aMax;
  logic [12:0] aAddr, aPos;
  logic        aSel, aWr, aReady, aBusy, aFin;
  logic [7:0]  aCnt;

  logic        bRst_n, bStart, bFace, bEnd;
  logic [31:0] bData, bMax;
  logic [12:0] bAddr, bPos;
  logic        bSel, bWr, bReady, bBusy, bFin;
  logic [7:0]  bCnt;

  om_max_search #(.MAP_W(AW), .MAP_H(AH), .SUP(ASUP), .MAX_FACES(16)) dutA (
    .iClk(iClk), .iReset_n(aRst_n), .iStart(aStart), .iData_from_OM(aData),
    .iFace_ready(aFace), .iEnd(aEnd), .oAddr_OM(aAddr), .oOm_sel(aSel), .oWr_OM(aWr),
    .oMax_val(aMax), .oPosition(aPos), .oOutput_ready(aReady), .oBusy(aBusy),
    .oFinish(aFin), .oFace_count(aCnt));

  om_max_search #(.MAP_W(BW), .MAP_H(BH), .SUP(BSUP), .MAX_FACES(BMAX)) dutB (
    .iClk(iClk), .iReset_n(bRst_n), .iStart(bStart), .iData_from_OM(bData),
    .iFace_ready(bFace), .iEnd(bEnd), .oAddr_OM(bAddr), .oOm_sel(bSel), .oWr_OM(bWr),
    .oMax_val(bMax), .oPosition(bPos), .oOutput_ready(bReady), .oBusy(bBusy),
    .oFinish(bFin), .oFace_count(bCnt));

  // Map memories with one-cycle read latency; every write is logged.
  logic [31:0] aMem [ASZ];
  logic [31:0] bMem [BSZ];
  int aWrLog [$];
  int bWrLog [$];

  always @(posedge iClk) begin
    aData <= aMem[aAddr];
    if (aWr) begin
      aMem[aAddr] = 32'd0;
      aWrLog.push_back(int'(aAddr));
    end
  end

  always @(posedge iClk) begin
    bData <= bMem[bAddr];
    if (bWr) begin
      bMem[bAddr] = 32'd0;
      bWrLog.push_back(int'(bAddr));
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: map contents and the write sequence suppression should produce.
  logic [31:0] model [];
  int expWr [$];

  function automatic int refArgmax(int sz);
    int p = 0;
    for (int i = 1; i < sz; i++) if (model[i] > model[p]) p = i;
    return p;
  endfunction

  function automatic void refSuppress(int w, int h, int sup, int p);
    int r0 = p / w;
    int c0 = p % w;
    for (int r = r0; r < r0 + sup && r < h; r++)
      for (int c = c0; c < c0 + sup && c < w; c++) begin
        model[r * w + c] = 32'd0;
        expWr.push_back(r * w + c);
      end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkWrites(input string tag, input int got[$]);
    int bad = 0;
    chk({tag, "_count"}, got.size(), expWr.size());
    for (int i = 0; i < got.size() && i < expWr.size(); i++) if (got[i] != expWr[i]) bad++;
    chk({tag, "_addr_mismatches"}, bad, 0);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic waitA(output int cyc);
    cyc = 0;
    while (aReady !== 1'b1 && cyc < 20000) begin tick(); cyc++; end
    chk("a_ready_seen", aReady, 1'b1);
  endtask

  task automatic waitB(output int cyc);
    cyc = 0;
    while (bReady !== 1'b1 && cyc < 500) begin tick(); cyc++; end
    chk("b_ready_seen", bReady, 1'b1);
  endtask

  task automatic startA();
    aStart = 1'b1;
    tick();
    aStart = 1'b0;
  endtask

  task automatic fillA(input logic [31:0] base, input int peak, input logic [31:0] pv);
    model = new[ASZ];
    for (int i = 0; i < ASZ; i++) begin aMem[i] = base; model[i] = base; end
    aMem[peak] = pv;
    model[peak] = pv;
    aWrLog.delete();
    expWr.delete();
  endtask

  task automatic chkResetA();
    chk("rst_addr", aAddr, 0);   chk("rst_sel", aSel, 0);    chk("rst_wr", aWr, 0);
    chk("rst_max", aMax, 0);     chk("rst_pos", aPos, 0);    chk("rst_ready", aReady, 0);
    chk("rst_busy", aBusy, 0);   chk("rst_finish", aFin, 0); chk("rst_count", aCnt, 0);
  endtask

  initial begin
    int cyc, p, n, verdict, faces, reports, diff;
    bit done;
    aRst_n = 1'b0; aStart = 1'b0; aFace = 1'b0; aEnd = 1'b0;
    bRst_n = 1'b0; bStart = 1'b0; bFace = 1'b0; bEnd = 1'b0;
    tick(); tick();
    chkResetA();
    aRst_n = 1'b1; bRst_n = 1'b1;
    tick();

    // Single peak: report, suppress 23x23 around it, rescan, reject.
    fillA(32'h10, 1000, 32'h0500_0000);
    startA();
    chk("peak_busy_after_start", aBusy, 1);
    waitA(cyc);
    chk("peak_latency", cyc + 1, ASZ + 3);
    p = refArgmax(ASZ);
    chk("peak_val", aMax, model[p]);
    chk("peak_pos", aPos, p);
    aFace = 1'b1; tick(); aFace = 1'b0;
    chk("peak_clear_wr", aWr, 1);
    chk("peak_clear_sel", aSel, 1);
    chk("peak_clear_first_addr", aAddr, 1000);
    refSuppress(AW, AH, ASUP, p);
    tick();
    chk("peak_ready_single", aReady, 0);
    waitA(cyc);
    chk("peak_rescan_lat", cyc + 1, 529 + ASZ + 2);
    chkWrites("peak_clear", aWrLog);
    p = refArgmax(ASZ);
    chk("peak_val2", aMax, model[p]);
    chk("peak_pos2", aPos, p);
    aEnd = 1'b1; tick(); aEnd = 1'b0;
    chk("peak_finish", aFin, 1);
    chk("peak_count", aCnt, 1);
    tick();
    chk("peak_finish_pulse", aFin, 0);
    chk("peak_idle", aBusy, 0);
    chk("peak_hold_val", aMax, model[p]);

    // Tie: two equal maxima, the lower address wins.
    model = new[ASZ];
    for (int i = 0; i < ASZ; i++) begin
      aMem[i] = $urandom_range(0, 32'h06FF_FFFF);
      model[i] = aMem[i];
    end
    aMem[200] = 32'h0700_0000;  model[200] = 32'h0700_0000;
    aMem[4000] = 32'h0700_0000; model[4000] = 32'h0700_0000;
    startA();
    waitA(cyc);
    p = refArgmax(ASZ);
    chk("tie_pos", aPos, p);
    chk("tie_val", aMax, model[p]);
    aEnd = 1'b1; tick(); aEnd = 1'b0;
    chk("tie_finish", aFin, 1);
    chk("tie_count_zeroed", aCnt, 0);
    tick();

    // Edge clip at the bottom-right corner, then a simultaneous verdict.
    fillA(32'h10, 6560, 32'h0500_0000);
    startA();
    waitA(cyc);
    p = refArgmax(ASZ);
    chk("clip_pos", aPos, p);
    chk("clip_val", aMax, model[p]);
    aFace = 1'b1; tick(); aFace = 1'b0;
    refSuppress(AW, AH, ASUP, p);
    waitA(cyc);
    chkWrites("clip_clear", aWrLog);
    p = refArgmax(ASZ);
    chk("clip_pos2", aPos, p);
    chk("clip_val2", aMax, model[p]);
    aFace = 1'b1; aEnd = 1'b1; tick(); aFace = 1'b0; aEnd = 1'b0;
    chk("both_finish", aFin, 1);
    chk("both_count", aCnt, 1);
    chk("both_no_wr", aWr, 0);
    tick(); tick();
    chkWrites("both_clear", aWrLog);

    // Start pulse while busy is ignored; reset mid-clear stops writes at once.
    fillA(32'h10, 1000, 32'h0500_0000);
    startA();
    for (int i = 0; i < 100; i++) tick();
    aStart = 1'b1; tick(); aStart = 1'b0;
    chk("guard_addr_seq", aAddr, 101);
    waitA(cyc);
    chk("guard_latency", cyc + 102, ASZ + 3);
    aFace = 1'b1; tick(); aFace = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("guard_mid_clear_wr", aWr, 1);
    n = aWrLog.size();
    aRst_n = 1'b0;
    #1;
    chk("guard_wr_cut", aWr, 0);
    tick();
    chkResetA();
    tick();
    aRst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("guard_no_more_wr", aWrLog.size(), n);
    chk("guard_idle", aBusy, 0);

    // Small map: random frames, first one always accepts to hit the face limit.
    for (int f = 0; f < 8; f++) begin
      model = new[BSZ];
      for (int i = 0; i < BSZ; i++) begin
        bMem[i] = $urandom_range(0, 15);
        model[i] = bMem[i];
      end
      bWrLog.delete();
      expWr.delete();
      bStart = 1'b1; tick(); bStart = 1'b0;
      faces = 0; reports = 0; done = 1'b0;
      while (!done && reports < 10) begin
        waitB(cyc);
        reports++;
        if (bReady !== 1'b1) break;
        p = refArgmax(BSZ);
        chk("rand_val", bMax, model[p]);
        chk("rand_pos", bPos, p);
        verdict = (f == 0) ? 1 : $urandom_range(0, 3);
        if (verdict == 0 || verdict == 3) begin
          bEnd = 1'b1; bFace = (verdict == 3); tick(); bEnd = 1'b0; bFace = 1'b0;
          done = 1'b1;
        end else begin
          bFace = 1'b1; tick(); bFace = 1'b0;
          faces++;
          if (faces == BMAX) done = 1'b1;
          else refSuppress(BW, BH, BSUP, p);
        end
        chk("rand_finish", bFin, done);
      end
      chk("rand_count", bCnt, faces);
      if (f == 0) chk("limit_reports", reports, BMAX);
      tick();
      chk("rand_idle", bBusy, 0);
      chkWrites("rand_clear", bWrLog);
      diff = 0;
      for (int i = 0; i < BSZ; i++) if (bMem[i] !== model[i]) diff++;
      chk("rand_map_cells_differing", diff, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
